// File: rtl/fetch_ctrl_if.sv
// Fetch-controller bundle: control inputs from hazard unit, fetch and M/W
// pipeline registers, plus the controller's address, status and counter outputs.
interface fetch_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             start_i;
    logic [63:0]      f_predPC_i;
    logic [2:0]       f_stat_i;
    logic             f_stall_i;
    logic [3:0]       m_icode_i;
    logic             m_cnd_i;
    logic [63:0]      m_valA_i;
    logic [3:0]       w_icode_i;
    logic [63:0]      w_valM_i;
    logic [2:0]       w_stat_i;
    logic [63:0]      pc_o;
    logic             fetch_valid_o;
    logic [1:0]       state_o;
    logic [2:0]       cpu_stat_o;
    logic [CNT_W-1:0] cycle_cnt_o;
    logic [CNT_W-1:0] instr_cnt_o;

    // Controller side.
    modport slave (
        input  start_i, f_predPC_i, f_stat_i, f_stall_i, m_icode_i, m_cnd_i, m_valA_i,
               w_icode_i, w_valM_i, w_stat_i,
        output pc_o, fetch_valid_o, state_o, cpu_stat_o, cycle_cnt_o, instr_cnt_o
    );

    // Pipeline / environment side.
    modport master (
        output start_i, f_predPC_i, f_stat_i, f_stall_i, m_icode_i, m_cnd_i, m_valA_i,
               w_icode_i, w_valM_i, w_stat_i,
        input  pc_o, fetch_valid_o, state_o, cpu_stat_o, cycle_cnt_o, instr_cnt_o
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Y86-64 fetch-stage sequencer: owns F_predPC, picks the fetch address,
// runs the IDLE/RUN/DRAIN/STOP machine and keeps saturating perf counters.
module fetch_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned CNT_W    = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    fetch_ctrl_if.slave ctrl_io
);
    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [3:0] INOP = 4'd1;
    localparam logic [3:0] IJXX = 4'd7;
    localparam logic [3:0] IRET = 4'd9;

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StStop  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [63:0]      pred_pc_q, pred_pc_d;
    logic [2:0]       cpu_stat_q, cpu_stat_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

    logic        mispredict;
    logic        ret_done;
    logic        redirect;
    logic        active;
    logic [63:0] pc;

    // Fetch address select: mispredicted jXX beats ret, which beats prediction.
    always_comb begin
        mispredict = (ctrl_io.m_icode_i == IJXX) && !ctrl_io.m_cnd_i;
        ret_done   = (ctrl_io.w_icode_i == IRET);
        redirect   = mispredict | ret_done;
        if (mispredict) begin
            pc = ctrl_io.m_valA_i;
        end else if (ret_done) begin
            pc = ctrl_io.w_valM_i;
        end else begin
            pc = pred_pc_q;
        end
    end

    // Next-state: FSM, predicted-PC register, final status and counters.
    always_comb begin
        state_d     = state_q;
        cpu_stat_d  = cpu_stat_q;
        active      = (state_q == StRun) || (state_q == StDrain);
        // Stall always wins for F_predPC, even when a redirect is in flight.
        pred_pc_d   = (active && !ctrl_io.f_stall_i) ? ctrl_io.f_predPC_i : pred_pc_q;
        cycle_cnt_d = cycle_cnt_q;
        instr_cnt_d = instr_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (ctrl_io.start_i) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (ctrl_io.w_stat_i != SAOK) begin
                    state_d    = StStop;
                    cpu_stat_d = ctrl_io.w_stat_i;
                end else if (ctrl_io.f_stat_i != SAOK && !ctrl_io.f_stall_i) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (ctrl_io.w_stat_i != SAOK) begin
                    state_d    = StStop;
                    cpu_stat_d = ctrl_io.w_stat_i;
                end else if (redirect) begin
                    // The halt/fault was on a squashed path; resume fetching.
                    state_d = StRun;
                end
            end
            StStop: begin
                state_d = StStop;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (active && cycle_cnt_q != CntMax) begin
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end
        if (active && ctrl_io.w_stat_i == SAOK && ctrl_io.w_icode_i != INOP &&
            instr_cnt_q != CntMax) begin
            instr_cnt_d = instr_cnt_q + CNT_W'(1);
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            pred_pc_q   <= RESET_PC;
            cpu_stat_q  <= SAOK;
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pred_pc_q   <= pred_pc_d;
            cpu_stat_q  <= cpu_stat_d;
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign ctrl_io.pc_o          = pc;
    assign ctrl_io.fetch_valid_o = (state_q == StRun);
    assign ctrl_io.state_o       = state_q;
    assign ctrl_io.cpu_stat_o    = cpu_stat_q;
    assign ctrl_io.cycle_cnt_o   = cycle_cnt_q;
    assign ctrl_io.instr_cnt_o   = instr_cnt_q;
endmodule
